minsel_sched: RTL

Sequential bit-serial minimum-key arbiter for the nine-requester elimination datapath. It resolves, one key bit per clock, the same MSB-first elimination that the combinational elimination netlist computes in parallel: a requester survives a bit round unless its bit is 1 while some other survivor's bit is 0. Remaining ties are broken round-robin, and exactly one winner is granted per arbitration. It sits between the request collectors and the shared resource, and replaces the wide combinational chain with a small, timing-friendly sequencer.

---
 rtl/minsel_sched_if.sv | 26 ++
 rtl/minsel_sched.sv | 132 +++++++++++++
 2 files changed

// File: rtl/minsel_sched_if.sv
// Request/result bundle for the bit-serial minimum-key arbiter.
// master drives start/req/key; slave (the arbiter) returns status and the winner.
interface minsel_sched_if #(
   parameter int N  = 9,
   parameter int KW = 4
);
   logic            start;
   logic [N-1:0]    req;
   logic [N*KW-1:0] key;
   logic            busy;
   logic            done;
   logic            none;
   logic [N-1:0]    grant;
   logic [3:0]      grant_idx;
   logic [KW-1:0]   min_key;

   modport master (
      output start, req, key,
      input  busy, done, none, grant, grant_idx, min_key
   );

   modport slave (
      input  start, req, key,
      output busy, done, none, grant, grant_idx, min_key
   );
endinterface

// File: rtl/minsel_sched.sv
// Bit-serial MSB-first minimum-key arbiter with round-robin tie break; result valid KW+2 cycles after start.
// No backpressure: start is only sampled in IDLE, starts seen while busy are dropped, result is held until the next start.
module minsel_sched #(
   parameter int N  = 9,
   parameter int KW = 4
) (
   input  logic          clk,
   input  logic          rst,
   minsel_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, TIE, DONE} state_t;

   state_t          state, state_nxt;
   logic [N-1:0]    surv;
   logic [N*KW-1:0] kreg;
   logic [2:0]      b;
   logic [3:0]      rr_ptr;
   logic [N-1:0]    grant;
   logic [3:0]      grant_idx;
   logic [KW-1:0]   min_key;
   logic            none;

   logic [N-1:0]    col;
   logic [N-1:0]    elim;
   logic            z;
   logic [3:0]      w;
   logic            w_vld;
   int              idx;

   // Current key bit column and the survivors that have a 0 there.
   always_comb begin
      col = '0;
      for (int i = 0; i < N; i++) begin
         col[i] = kreg[i*KW + int'(b)];
      end
      elim = surv & ~col;
      z    = |elim;
   end

   // Round-robin pick among the remaining survivors, starting at rr_ptr.
   always_comb begin
      w     = '0;
      w_vld = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!w_vld && surv[idx]) begin
            w_vld = 1'b1;
            w     = 4'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         IDLE: if (bus.start) state_nxt = SCAN;
         SCAN: begin
            bus.busy = 1'b1;
            if (b == 3'd0) state_nxt = TIE;
         end
         TIE: begin
            bus.busy  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            bus.busy  = 1'b1;
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         surv      <= '0;
         kreg      <= '0;
         b         <= '0;
         rr_ptr    <= '0;
         grant     <= '0;
         grant_idx <= '0;
         min_key   <= '0;
         none      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  surv      <= bus.req;
                  kreg      <= bus.key;
                  b         <= 3'(KW-1);
                  grant     <= '0;
                  grant_idx <= '0;
                  min_key   <= '0;
                  none      <= 1'b0;
               end
            end
            SCAN: begin
               if (z) surv <= elim;
               if (b != 3'd0) b <= b - 3'd1;
            end
            TIE: begin
               if (w_vld) begin
                  grant     <= N'(1) << w;
                  grant_idx <= w;
                  min_key   <= kreg[int'(w)*KW +: KW];
                  rr_ptr    <= (int'(w) == N-1) ? 4'd0 : w + 4'd1;
               end else begin
                  grant     <= '0;
                  grant_idx <= '0;
                  min_key   <= '0;
                  none      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.grant     = grant;
   assign bus.grant_idx = grant_idx;
   assign bus.min_key   = min_key;
   assign bus.none      = none;
endmodule
